// File: rtl/fp_accum_n.sv
// Single-precision accumulator: sums N_TERMS products per frame through one
// combinational IEEE-754 adder into a single accumulator register.
module fp_accum_n #(
    parameter int unsigned N_TERMS = 9,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_in,
    input  logic        clear,
    input  logic [31:0] data_in,
    output logic [31:0] sum_out,
    output logic        valid_out,
    output logic        busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      sum_q, sum_d;
    logic             vout_q, vout_d;

    // Adder datapath signals
    logic        a_s, b_s;
    logic [7:0]  a_e, b_e;
    logic [23:0] a_m, b_m;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        swap;
    logic        big_s, sml_s;
    logic [7:0]  big_e, sml_e, exp_diff;
    logic [23:0] big_m, sml_m;
    logic [49:0] shifted;
    logic [26:0] aligned;
    logic [27:0] raw;
    logic [4:0]  lz;
    logic        lz_found;
    logic [26:0] norm;
    logic [9:0]  exp_n, exp_r;
    logic        rnd_up;
    logic [24:0] man_r;
    logic [22:0] frac_r;
    logic [31:0] add_res;

    always_comb begin
        a_s   = acc_q[31];
        a_e   = acc_q[30:23];
        b_s   = data_in[31];
        b_e   = data_in[30:23];
        // Denormals have a zero exponent and become signed zero
        a_m   = (a_e == 8'h00) ? '0 : {1'b1, acc_q[22:0]};
        b_m   = (b_e == 8'h00) ? '0 : {1'b1, data_in[22:0]};
        a_nan = (a_e == 8'hFF) && (acc_q[22:0] != '0);
        b_nan = (b_e == 8'hFF) && (data_in[22:0] != '0);
        a_inf = (a_e == 8'hFF) && (acc_q[22:0] == '0);
        b_inf = (b_e == 8'hFF) && (data_in[22:0] == '0);
    end

    always_comb begin
        swap  = {b_e, b_m} > {a_e, a_m};
        big_s = swap ? b_s : a_s;
        big_e = swap ? b_e : a_e;
        big_m = swap ? b_m : a_m;
        sml_s = swap ? a_s : b_s;
        sml_e = swap ? a_e : b_e;
        sml_m = swap ? a_m : b_m;
        exp_diff = big_e - sml_e;

        // Bits [49:26] significand, [25] guard, [24] round, [23:0] feed sticky
        shifted = {sml_m, 26'b0} >> exp_diff;
        if (exp_diff >= 8'd26) begin
            aligned = {26'b0, |sml_m};
        end else begin
            aligned = {shifted[49:24], |shifted[23:0]};
        end

        if (big_s ^ sml_s) begin
            raw = {1'b0, big_m, 3'b000} - {1'b0, aligned};
        end else begin
            raw = {1'b0, big_m, 3'b000} + {1'b0, aligned};
        end
    end

    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (!lz_found) begin
                if (raw[26 - i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz = lz + 5'd1;
                end
            end
        end

        if (raw[27]) begin
            norm  = {raw[27:2], raw[1] | raw[0]};
            exp_n = {2'b00, big_e} + 10'd1;
        end else begin
            norm  = raw[26:0] << lz;
            exp_n = {2'b00, big_e} - {5'b00000, lz};
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        man_r  = {1'b0, norm[26:3]} + {24'b0, rnd_up};
        if (man_r[24]) begin
            frac_r = man_r[23:1];
            exp_r  = exp_n + 10'd1;
        end else begin
            frac_r = man_r[22:0];
            exp_r  = exp_n;
        end
    end

    always_comb begin
        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
            add_res = 32'h7FC0_0000;
        end else if (a_inf) begin
            add_res = acc_q;
        end else if (b_inf) begin
            add_res = data_in;
        end else if (raw == '0) begin
            add_res = {a_s & b_s, 31'b0};
        end else if (exp_n[9] || (exp_n == '0)) begin
            add_res = {big_s, 31'b0};
        end else if (exp_r >= 10'd255) begin
            add_res = {big_s, 8'hFF, 23'b0};
        end else begin
            add_res = {big_s, exp_r[7:0], frac_r};
        end
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        vout_d = 1'b0;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (valid_in) begin
            if (cnt_q == '0) begin
                // First term is loaded so a lone -0 keeps its sign
                acc_d = data_in;
                cnt_d = ONE_CNT;
            end else if (cnt_q == LAST_CNT) begin
                sum_d  = add_res;
                vout_d = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
            end else begin
                acc_d = add_res;
                cnt_d = cnt_q + ONE_CNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
            vout_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            vout_q <= vout_d;
        end
    end

    assign sum_out   = sum_q;
    assign valid_out = vout_q;
    assign busy      = (cnt_q != '0);

endmodule
